reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Architectural register file with an integrated pending-write scoreboard, responding to the ID stage's register read/write requests. ID presents two read ports and the destination of the instruction being issued. WB presents the committing write. The block returns operands with WB-to-ID bypass and raises `stall_req` when an operand is still owed by an in-flight instruction.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register width (matches `DATA_BUS`).
- `REG_NUM`, 32, number of registers; register 0 is hardwired zero.
- `CNT_WIDTH`, 2, width of each per-register in-flight counter (max in flight per register = 2^CNT_WIDTH-1 = 3).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `read_en_1`  in  1  port 1 read request.
- `read_addr_1`  in  5  port 1 register index.
- `read_en_2`  in  1  port 2 read request.
- `read_addr_2`  in  5  port 2 register index.
- `read_data_1`  out  DATA_WIDTH  port 1 operand.
- `read_data_2`  out  DATA_WIDTH  port 2 operand.
- `issue_en`  in  1  ID instruction advances to EX this cycle if not stalled.
- `issue_write_en`  in  1  issuing instruction writes a register.
- `issue_write_addr`  in  5  its destination index.
- `write_en`  in  1  WB commit valid.
- `write_addr`  in  5  WB destination.
- `write_data`  in  DATA_WIDTH  WB value.
- `flush`  in  1  all in-flight instructions squashed.
- `stall_req`  out  1  ID must hold this cycle.

## Operation
- Storage: REG_NUM x DATA_WIDTH array plus REG_NUM counters `cnt[i]`. `cnt[0]` is constant 0.
- Read (combinational, per port):
  - `en`=0 or `addr`=0 -> 0.
  - Else if `write_en` and `write_addr`==`addr` -> `write_data` (bypass).
  - Else -> array value.
- Hazard per port, `hit_k`: `en` and `addr`!=0 and `cnt[addr]`!=0, excluding the case where `write_en` and `write_addr`==`addr` and `cnt[addr]`==1 (the last owed write is being bypassed).
- Capacity hazard: `issue_en` and `issue_write_en` and `issue_write_addr`!=0 and `cnt[issue_write_addr]`==max.
- `stall_req` = `hit_1` | `hit_2` | capacity hazard.
- `inc` = `issue_en` & !`stall_req` & `issue_write_en` & (`issue_write_addr`!=0).
- `dec` = `write_en` & (`write_addr`!=0) & (`cnt[write_addr]`!=0).
- Counter update:
  - `inc` and `dec` on the same register -> unchanged.
  - Otherwise each applies to its own register.
  - `dec` on a zero counter is suppressed; the data write still happens.
- Array write: if `write_en` and `write_addr`!=0, array[`write_addr`] <= `write_data`. Writes to register 0 are ignored.
- `flush`:
  - All counters clear to 0 at the next edge, overriding `inc` and `dec`.
  - Array contents are untouched; the same-cycle WB write still commits.
  - `stall_req` is still computed from the current counters during the flush cycle.

## Timing
- Reset: array all 0, all counters 0. Hence `read_data_*`=0 and `stall_req`=0 immediately, while `rst` is high, independent of `clk`.
- Reset mid-operation clears all pending state; no partial counters survive.
- Read latency 0 (combinational). Write visible in the array on the cycle after the edge; visible via bypass in the same cycle.
- Counter effects are visible the cycle after the edge: an issued write makes a dependent read in the next cycle stall.
- `stall_req` is purely combinational from inputs and state, with no registered delay. ID must not advance when it is 1.
- 5-bit addresses; no wrap. Counters never wrap: increments at max are blocked by the capacity hazard, decrements at 0 are suppressed.

## Test plan
- Reset then read: `rst` pulse; read r5 and r0 on both ports -> data 0, `stall_req`=0; write r0=0xFFFF_FFFF -> r0 still reads 0.
- Write/bypass: WB write r3=0x1234_5678 with same-cycle read r3 -> 0x12345678 that cycle; next cycle with no WB, array read -> 0x12345678.
- RAW stall: issue writing r7 -> next cycle read r7 gives `stall_req`=1. Cycle where WB writes r7=0xA5 -> `stall_req`=0 and data 0xA5. After that, cnt[r7]=0.
- Multiple in flight: issue r9 three times -> a fourth issue to r9 asserts `stall_req` and `cnt` stays 3. One WB to r9 -> cnt=2, and a read of r9 still stalls.
- Simultaneous inc/dec: cnt[r4]=1, issue to r4 and WB r4 in the same cycle -> cnt[r4] stays 1 and the array is updated.
- Flush: cnt[r2]=2, cnt[r6]=1, `flush` with WB r6=0x77 -> next cycle all counters 0, reads of r2/r6 do not stall, r6 reads 0x77.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: ID read/issue, WB commit and stall signals of the register file.
interface reg_file_sb_if #(parameter int DATA_WIDTH = 32);
  logic                  read_en_1;
  logic [4:0]            read_addr_1;
  logic                  read_en_2;
  logic [4:0]            read_addr_2;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic                  issue_en;
  logic                  issue_write_en;
  logic [4:0]            issue_write_addr;
  logic                  write_en;
  logic [4:0]            write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  flush;
  logic                  stall_req;
  modport master (
    output read_en_1, read_addr_1, read_en_2, read_addr_2,
    output issue_en, issue_write_en, issue_write_addr,
    output write_en, write_addr, write_data, flush,
    input  read_data_1, read_data_2, stall_req
  );
  modport slave (
    input  read_en_1, read_addr_1, read_en_2, read_addr_2,
    input  issue_en, issue_write_en, issue_write_addr,
    input  write_en, write_addr, write_data, flush,
    output read_data_1, read_data_2, stall_req
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with per-register pending-write counters, WB->ID bypass
// and an ID stall request when an operand is still owed or a counter is full.
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int CNT_WIDTH  = 2
) (
  input logic         clk,
  input logic         rst,
  reg_file_sb_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  logic [DATA_WIDTH-1:0] mem [REG_NUM];
  logic [CNT_WIDTH-1:0]  cnt [REG_NUM];
  logic byp_1, byp_2, hit_1, hit_2, cap, stall, inc, dec;
  always_comb begin
    byp_1 = bus.write_en && bus.write_addr == bus.read_addr_1;
    byp_2 = bus.write_en && bus.write_addr == bus.read_addr_2;
    bus.read_data_1 = (!bus.read_en_1 || bus.read_addr_1 == '0) ? '0 : byp_1 ? bus.write_data : mem[bus.read_addr_1];
    bus.read_data_2 = (!bus.read_en_2 || bus.read_addr_2 == '0) ? '0 : byp_2 ? bus.write_data : mem[bus.read_addr_2];
    // an operand whose last owed write is committing right now is covered by the bypass
    hit_1 = bus.read_en_1 && bus.read_addr_1 != '0 && cnt[bus.read_addr_1] != '0 &&
            !(byp_1 && cnt[bus.read_addr_1] == CNT_ONE);
    hit_2 = bus.read_en_2 && bus.read_addr_2 != '0 && cnt[bus.read_addr_2] != '0 &&
            !(byp_2 && cnt[bus.read_addr_2] == CNT_ONE);
    cap = bus.issue_en && bus.issue_write_en && bus.issue_write_addr != '0 &&
          cnt[bus.issue_write_addr] == CNT_MAX;
    stall = hit_1 || hit_2 || cap;
    bus.stall_req = stall;
    inc = bus.issue_en && !stall && bus.issue_write_en && bus.issue_write_addr != '0;
    dec = bus.write_en && bus.write_addr != '0 && cnt[bus.write_addr] != '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        mem[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      if (bus.write_en && bus.write_addr != '0) mem[bus.write_addr] <= bus.write_data;
      // counter 0 is never touched, so it stays at its reset value
      for (int i = 1; i < REG_NUM; i++) begin
        if (bus.flush) cnt[i] <= '0;
        else if (inc && bus.issue_write_addr == 5'(i) && !(dec && bus.write_addr == 5'(i))) cnt[i] <= cnt[i] + CNT_ONE;
        else if (dec && bus.write_addr == 5'(i) && !(inc && bus.issue_write_addr == 5'(i))) cnt[i] <= cnt[i] - CNT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scenario tasks push expected operands/stall into a scoreboard queue
// at drive time and pop/compare them against the combinational DUT outputs.
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  reg_file_sb_if #(.DATA_WIDTH(32)) bus ();
  reg_file_sb #(.DATA_WIDTH(32), .REG_NUM(32), .CNT_WIDTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        st;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] m_mem [32];
  int          m_cnt [32];
  int checks = 0;
  int errors = 0;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1);
  end
  function automatic logic [31:0] m_read(logic en, logic [4:0] a);
    if (!en || a == 5'd0) return 32'd0;
    if (bus.write_en && bus.write_addr == a) return bus.write_data;
    return m_mem[a];
  endfunction
  function automatic logic m_hit(logic en, logic [4:0] a);
    return en && a != 5'd0 && m_cnt[a] != 0 && !(bus.write_en && bus.write_addr == a && m_cnt[a] == 1);
  endfunction
  function automatic logic m_stall();
    return m_hit(bus.read_en_1, bus.read_addr_1) || m_hit(bus.read_en_2, bus.read_addr_2) ||
           (bus.issue_en && bus.issue_write_en && bus.issue_write_addr != 5'd0 && m_cnt[bus.issue_write_addr] == 3);
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 32'd0;
      m_cnt[i] = 0;
    end
  endtask
  // row: ie iwe iwa e1 a1 e2 a2 we wa wd flush exp_d1 exp_d2 exp_stall
  task automatic drive(input int s[14], input bit use_model);
    bus.issue_en         = s[0] != 0;
    bus.issue_write_en   = s[1] != 0;
    bus.issue_write_addr = 5'(s[2]);
    bus.read_en_1        = s[3] != 0;
    bus.read_addr_1      = 5'(s[4]);
    bus.read_en_2        = s[5] != 0;
    bus.read_addr_2      = 5'(s[6]);
    bus.write_en         = s[7] != 0;
    bus.write_addr       = 5'(s[8]);
    bus.write_data       = 32'(s[9]);
    bus.flush            = s[10] != 0;
    #1;
    if (use_model) q.push_back('{m_read(bus.read_en_1, bus.read_addr_1), m_read(bus.read_en_2, bus.read_addr_2), m_stall()});
    else q.push_back('{32'(s[11]), 32'(s[12]), s[13] != 0});
  endtask
  task automatic tick();
    logic st, inc, dec;
    int iwa, wa;
    st  = m_stall();
    iwa = int'(bus.issue_write_addr);
    wa  = int'(bus.write_addr);
    inc = bus.issue_en && !st && bus.issue_write_en && iwa != 0;
    dec = bus.write_en && wa != 0 && m_cnt[wa] != 0;
    @(posedge clk);
    if (bus.flush) for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    else if (!(inc && dec && iwa == wa)) begin
      if (inc) m_cnt[iwa]++;
      if (dec) m_cnt[wa]--;
    end
    if (bus.write_en && wa != 0) m_mem[wa] = bus.write_data;
    #1;
  endtask
  task automatic test_reset();
    int t[3][14] = '{
      '{0,0,0, 1,5,1,0, 0,0,0,             0, 0,0,0},
      '{0,0,0, 1,0,1,0, 1,0,32'hFFFF_FFFF, 0, 0,0,0},
      '{0,0,0, 1,0,1,5, 0,0,0,             0, 0,0,0}};
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      drive(t[k], 1'b0);
      e = q.pop_front();
      checks++;
      if (bus.read_data_1 !== e.d1 || bus.read_data_2 !== e.d2 || bus.stall_req !== e.st) begin
        errors++;
        $display("FAIL reset step %0d: got d1=%h d2=%h stall=%b want d1=%h d2=%h stall=%b",
                 k, bus.read_data_1, bus.read_data_2, bus.stall_req, e.d1, e.d2, e.st);
      end
      if (k == 0) begin
        @(negedge clk);
        rst = 1'b0;
      end else tick();
    end
  endtask
  task automatic test_write_bypass();
    int t[2][14] = '{
      '{0,0,0, 1,3,0,0, 1,3,32'h1234_5678, 0, 32'h1234_5678,0,0},
      '{0,0,0, 1,3,1,3, 0,0,0,             0, 32'h1234_5678,32'h1234_5678,0}};
    for (int k = 0; k < 2; k++) begin
      drive(t[k], 1'b0);
      e = q.pop_front();
      checks++;
      if (bus.read_data_1 !== e.d1 || bus.read_data_2 !== e.d2 || bus.stall_req !== e.st) begin
        errors++;
        $display("FAIL bypass step %0d: got d1=%h d2=%h stall=%b want d1=%h d2=%h stall=%b",
                 k, bus.read_data_1, bus.read_data_2, bus.stall_req, e.d1, e.d2, e.st);
      end
      tick();
    end
  endtask
  task automatic test_raw_stall();
    int t[4][14] = '{
      '{1,1,7, 0,0,0,0, 0,0,0,     0, 0,0,0},
      '{0,0,0, 1,7,0,0, 0,0,0,     0, 0,0,1},
      '{0,0,0, 1,7,0,0, 1,7,'hA5,  0, 'hA5,0,0},
      '{0,0,0, 1,7,1,7, 0,0,0,     0, 'hA5,'hA5,0}};
    for (int k = 0; k < 4; k++) begin
      drive(t[k], 1'b0);
      e = q.pop_front();
      checks++;
      if (bus.read_data_1 !== e.d1 || bus.read_data_2 !== e.d2 || bus.stall_req !== e.st) begin
        errors++;
        $display("FAIL raw step %0d: got d1=%h d2=%h stall=%b want d1=%h d2=%h stall=%b",
                 k, bus.read_data_1, bus.read_data_2, bus.stall_req, e.d1, e.d2, e.st);
      end
      tick();
    end
  endtask
  task automatic test_multi_inflight();
    int t[9][14] = '{
      '{1,1,9, 0,0,0,0, 0,0,0,    0, 0,0,0},
      '{1,1,9, 0,0,0,0, 0,0,0,    0, 0,0,0},
      '{1,1,9, 0,0,0,0, 0,0,0,    0, 0,0,0},
      '{1,1,9, 0,0,0,0, 0,0,0,    0, 0,0,1},
      '{1,1,9, 0,0,0,0, 0,0,0,    0, 0,0,1},
      '{0,0,0, 0,0,0,0, 1,9,'h99, 0, 0,0,0},
      '{0,0,0, 0,0,1,9, 0,0,0,    0, 0,'h99,1},
      '{0,0,0, 1,9,0,0, 1,9,'h9A, 0, 'h9A,0,1},
      '{0,0,0, 1,9,0,0, 1,9,'h9B, 0, 'h9B,0,0}};
    for (int k = 0; k < 9; k++) begin
      drive(t[k], 1'b0);
      e = q.pop_front();
      checks++;
      if (bus.read_data_1 !== e.d1 || bus.read_data_2 !== e.d2 || bus.stall_req !== e.st) begin
        errors++;
        $display("FAIL multi step %0d: got d1=%h d2=%h stall=%b want d1=%h d2=%h stall=%b",
                 k, bus.read_data_1, bus.read_data_2, bus.stall_req, e.d1, e.d2, e.st);
      end
      tick();
    end
  endtask
  task automatic test_inc_dec();
    int t[7][14] = '{
      '{1,1,4,  0,0,0,0,  0,0,0,     0, 0,0,0},
      '{1,1,4,  0,0,0,0,  1,4,'h44,  0, 0,0,0},
      '{0,0,0,  1,4,0,0,  0,0,0,     0, 'h44,0,1},
      '{0,0,0,  1,4,0,0,  1,4,'h45,  0, 'h45,0,0},
      '{0,0,0,  1,4,0,0,  0,0,0,     0, 'h45,0,0},
      '{0,0,0,  1,10,0,0, 1,10,'hAB, 0, 'hAB,0,0},
      '{0,0,0,  1,10,1,4, 0,0,0,     0, 'hAB,'h45,0}};
    for (int k = 0; k < 7; k++) begin
      drive(t[k], 1'b0);
      e = q.pop_front();
      checks++;
      if (bus.read_data_1 !== e.d1 || bus.read_data_2 !== e.d2 || bus.stall_req !== e.st) begin
        errors++;
        $display("FAIL incdec step %0d: got d1=%h d2=%h stall=%b want d1=%h d2=%h stall=%b",
                 k, bus.read_data_1, bus.read_data_2, bus.stall_req, e.d1, e.d2, e.st);
      end
      tick();
    end
  endtask
  task automatic test_flush();
    int t[6][14] = '{
      '{1,1,2, 0,0,0,0, 0,0,0,    0, 0,0,0},
      '{1,1,2, 0,0,0,0, 0,0,0,    0, 0,0,0},
      '{1,1,6, 0,0,0,0, 0,0,0,    0, 0,0,0},
      '{1,1,6, 1,2,1,6, 1,6,'h77, 1, 0,'h77,1},
      '{0,0,0, 1,2,1,6, 0,0,0,    0, 0,'h77,0},
      '{1,1,2, 0,0,1,2, 0,0,0,    0, 0,0,0}};
    for (int k = 0; k < 6; k++) begin
      drive(t[k], 1'b0);
      e = q.pop_front();
      checks++;
      if (bus.read_data_1 !== e.d1 || bus.read_data_2 !== e.d2 || bus.stall_req !== e.st) begin
        errors++;
        $display("FAIL flush step %0d: got d1=%h d2=%h stall=%b want d1=%h d2=%h stall=%b",
                 k, bus.read_data_1, bus.read_data_2, bus.stall_req, e.d1, e.d2, e.st);
      end
      tick();
    end
  endtask
  task automatic test_reset_mid();
    int t[3][14] = '{
      '{1,1,5, 0,0,0,0, 0,0,0, 0, 0,0,0},
      '{0,0,0, 1,5,1,3, 0,0,0, 0, 0,0,0},
      '{0,0,0, 1,5,1,2, 0,0,0, 0, 0,0,0}};
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        rst = 1'b1;
        model_reset();
      end
      drive(t[k], 1'b0);
      e = q.pop_front();
      checks++;
      if (bus.read_data_1 !== e.d1 || bus.read_data_2 !== e.d2 || bus.stall_req !== e.st) begin
        errors++;
        $display("FAIL reset_mid step %0d: got d1=%h d2=%h stall=%b want d1=%h d2=%h stall=%b",
                 k, bus.read_data_1, bus.read_data_2, bus.stall_req, e.d1, e.d2, e.st);
      end
      if (k == 1) begin
        @(negedge clk);
        rst = 1'b0;
      end else tick();
    end
  endtask
  task automatic test_back_to_back();
    int s[14];
    for (int k = 0; k < 300; k++) begin
      s[0]  = int'($urandom_range(0, 1));
      s[1]  = int'($urandom_range(0, 3) != 0);
      s[2]  = int'($urandom_range(0, 7));
      s[3]  = int'($urandom_range(0, 1));
      s[4]  = int'($urandom_range(0, 7));
      s[5]  = int'($urandom_range(0, 1));
      s[6]  = int'($urandom_range(0, 7));
      s[7]  = int'($urandom_range(0, 1));
      s[8]  = int'($urandom_range(0, 7));
      s[9]  = int'($urandom);
      s[10] = int'($urandom_range(0, 15) == 0);
      s[11] = 0;
      s[12] = 0;
      s[13] = 0;
      drive(s, 1'b1);
      e = q.pop_front();
      checks++;
      if (bus.read_data_1 !== e.d1 || bus.read_data_2 !== e.d2 || bus.stall_req !== e.st) begin
        errors++;
        $display("FAIL b2b cycle %0d: got d1=%h d2=%h stall=%b want d1=%h d2=%h stall=%b",
                 k, bus.read_data_1, bus.read_data_2, bus.stall_req, e.d1, e.d2, e.st);
      end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_write_bypass();
    test_raw_stall();
    test_multi_inflight();
    test_inc_dec();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
